// File: rtl/id_hazard_scoreboard.sv
// RAW hazard scoreboard for the ID stage: tracks EX/MEM/WB destination tags and
// produces the ID stall, per-port forwarding selects and a saturating stall counter.
module id_hazard_scoreboard #(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rj,
    input  logic             id_rj_re,
    input  logic [4:0]       id_rkd,
    input  logic             id_rkd_re,
    input  logic [4:0]       id_dest,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             id_go,
    input  logic             ex_go,
    input  logic             mem_go,
    input  logic             wb_go,
    output logic             stall,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt
);

    logic       ex_v, ex_we, ex_ld;
    logic [4:0] ex_dest;
    logic       mem_v, mem_we, mem_ld;
    logic [4:0] mem_dest;
    logic       wb_v, wb_we, wb_ld;
    logic [4:0] wb_dest;

    // A load into a slot takes precedence over its own advance, so the slots shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v     <= 1'b0;
            ex_we    <= 1'b0;
            ex_ld    <= 1'b0;
            ex_dest  <= 5'd0;
            mem_v    <= 1'b0;
            mem_we   <= 1'b0;
            mem_ld   <= 1'b0;
            mem_dest <= 5'd0;
            wb_v     <= 1'b0;
            wb_we    <= 1'b0;
            wb_ld    <= 1'b0;
            wb_dest  <= 5'd0;
        end else begin
            if (id_go) begin
                ex_v    <= 1'b1;
                ex_we   <= id_we;
                ex_ld   <= id_is_load;
                ex_dest <= id_dest;
            end else if (ex_go) begin
                ex_v <= 1'b0;
            end
            if (ex_go) begin
                mem_v    <= ex_v;
                mem_we   <= ex_we;
                mem_ld   <= ex_ld;
                mem_dest <= ex_dest;
            end else if (mem_go) begin
                mem_v <= 1'b0;
            end
            if (mem_go) begin
                wb_v    <= mem_v;
                wb_we   <= mem_we;
                wb_ld   <= mem_ld;
                wb_dest <= mem_dest;
            end else if (wb_go) begin
                wb_v <= 1'b0;
            end
        end
    end

    logic ex_prod, mem_prod, wb_prod;
    logic m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb;
    logic [1:0] sel1_raw, sel2_raw;
    logic load_use, any_match;

    assign ex_prod  = ex_v  & ex_we  & (ex_dest  != 5'd0);
    assign mem_prod = mem_v & mem_we & (mem_dest != 5'd0);
    assign wb_prod  = wb_v  & wb_we  & (wb_dest  != 5'd0);

    assign m1_ex  = id_rj_re  & ex_prod  & (ex_dest  == id_rj);
    assign m1_mem = id_rj_re  & mem_prod & (mem_dest == id_rj);
    assign m1_wb  = id_rj_re  & wb_prod  & (wb_dest  == id_rj);
    assign m2_ex  = id_rkd_re & ex_prod  & (ex_dest  == id_rkd);
    assign m2_mem = id_rkd_re & mem_prod & (mem_dest == id_rkd);
    assign m2_wb  = id_rkd_re & wb_prod  & (wb_dest  == id_rkd);

    // Youngest match wins; a load only blocks when it is still the EX-slot producer.
    always_comb begin
        sel1_raw = 2'd0;
        if (m1_ex)       sel1_raw = 2'd1;
        else if (m1_mem) sel1_raw = 2'd2;
        else if (m1_wb)  sel1_raw = 2'd3;
        sel2_raw = 2'd0;
        if (m2_ex)       sel2_raw = 2'd1;
        else if (m2_mem) sel2_raw = 2'd2;
        else if (m2_wb)  sel2_raw = 2'd3;
        load_use  = (m1_ex | m2_ex) & ex_ld;
        any_match = m1_ex | m1_mem | m1_wb | m2_ex | m2_mem | m2_wb;
        if (FWD_EN != 0) begin
            stall    = id_valid & load_use;
            fwd_sel1 = sel1_raw;
            fwd_sel2 = sel2_raw;
        end else begin
            stall    = id_valid & any_match;
            fwd_sel1 = 2'd0;
            fwd_sel2 = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Scoreboard bench: directed ID/pipeline vectors push expected outputs, a negedge
// monitor pops and compares. Instance f has forwarding, instance n does not (2-bit counter).
module tb_id_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_f, valid_n;
    logic [4:0] rj, rkd, dest;
    logic       rj_re, rkd_re, we, is_load, id_go, pipe_go;
    logic       stall_f, stall_n;
    logic [1:0] sel1_f, sel2_f, sel1_n, sel2_n;
    logic [31:0] cnt_f;
    logic [1:0]  cnt_n;

    typedef struct {
        int          dut;
        logic        stall;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.FWD_EN(1), .CNT_W(32)) dut_f (
        .clk(clk), .reset(reset), .id_valid(valid_f),
        .id_rj(rj), .id_rj_re(rj_re), .id_rkd(rkd), .id_rkd_re(rkd_re),
        .id_dest(dest), .id_we(we), .id_is_load(is_load), .id_go(id_go),
        .ex_go(pipe_go), .mem_go(pipe_go), .wb_go(pipe_go),
        .stall(stall_f), .fwd_sel1(sel1_f), .fwd_sel2(sel2_f), .stall_cnt(cnt_f)
    );

    id_hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) dut_n (
        .clk(clk), .reset(reset), .id_valid(valid_n),
        .id_rj(rj), .id_rj_re(rj_re), .id_rkd(rkd), .id_rkd_re(rkd_re),
        .id_dest(dest), .id_we(we), .id_is_load(is_load), .id_go(id_go),
        .ex_go(pipe_go), .mem_go(pipe_go), .wb_go(pipe_go),
        .stall(stall_n), .fwd_sel1(sel1_n), .fwd_sel2(sel2_n), .stall_cnt(cnt_n)
    );

    // Monitor: compares every queued expectation against the instance it targets.
    always @(negedge clk) begin
        if (valid_f && stall_f && id_go) begin
            errors++;
            $display("[TB] FAIL go_during_stall_f: id_go=1 while stall=1");
        end
        if (valid_n && stall_n && id_go) begin
            errors++;
            $display("[TB] FAIL go_during_stall_n: id_go=1 while stall=1");
        end
        while (exp_q.size() > 0) begin
            exp_t e;
            logic        a_stall;
            logic [1:0]  a_s1, a_s2;
            logic [31:0] a_cnt;
            e = exp_q.pop_front();
            if (e.dut == 0) begin
                a_stall = stall_f; a_s1 = sel1_f; a_s2 = sel2_f; a_cnt = cnt_f;
            end else begin
                a_stall = stall_n; a_s1 = sel1_n; a_s2 = sel2_n; a_cnt = {30'd0, cnt_n};
            end
            checks++;
            if (a_stall !== e.stall || a_s1 !== e.s1 || a_s2 !== e.s2 || a_cnt !== e.cnt) begin
                errors++;
                $display("[TB] FAIL %s: got stall=%0b sel1=%0d sel2=%0d cnt=%0d, want stall=%0b sel1=%0d sel2=%0d cnt=%0d",
                         e.name, a_stall, a_s1, a_s2, a_cnt, e.stall, e.s1, e.s2, e.cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int tgt, input logic [4:0] a1, input logic re1,
                                  input logic [4:0] a2, input logic re2, input logic [4:0] d,
                                  input logic w, input logic ld, input logic go, input logic pgo);
        valid_f = (tgt == 0);
        valid_n = (tgt == 1);
        rj = a1; rj_re = re1; rkd = a2; rkd_re = re2;
        dest = d; we = w; is_load = ld; id_go = go; pipe_go = pgo;
    endtask

    task automatic check_output(input int d, input logic s, input logic [1:0] s1,
                                input logic [1:0] s2, input logic [31:0] c, input string n);
        exp_t e;
        e.dut = d; e.stall = s; e.s1 = s1; e.s2 = s2; e.cnt = c; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(-1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(-1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check_output(0, 1'b0, 2'd0, 2'd0, 32'd0, "reset_f");
        check_output(1, 1'b0, 2'd0, 2'd0, 32'd0, "reset_n");
        step();

        // Dependent ALU ops: forward from EX, then from MEM.
        apply_stimulus(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        check_output(0, 1'b0, 2'd0, 2'd0, 32'd0, "alu_issue");
        step();
        apply_stimulus(0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        check_output(0, 1'b0, 2'd1, 2'd0, 32'd0, "alu_fwd_ex");
        step();
        apply_stimulus(0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_output(0, 1'b0, 2'd2, 2'd0, 32'd0, "alu_fwd_mem");
        step();
        idle(3);

        // Load-use: one stall cycle, then forward from MEM.
        apply_stimulus(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        check_output(0, 1'b0, 2'd0, 2'd0, 32'd0, "ld_issue");
        step();
        apply_stimulus(0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output(0, 1'b1, 2'd0, 2'd1, 32'd0, "ld_use_stall");
        step();
        apply_stimulus(0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        check_output(0, 1'b0, 2'd0, 2'd2, 32'd1, "ld_use_fwd_mem");
        step();
        idle(3);

        // r0 producer and disabled read ports never match.
        apply_stimulus(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        apply_stimulus(0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1);
        check_output(0, 1'b0, 2'd0, 2'd0, 32'd1, "r0_read");
        step();
        apply_stimulus(0, 5'd10, 1'b0, 5'd10, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(0, 1'b0, 2'd0, 2'd0, 32'd1, "re_disabled");
        step();
        idle(3);

        // Priority: r3 in EX, MEM and WB at once.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
            step();
        end
        apply_stimulus(0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(0, 1'b0, 2'd1, 2'd1, 32'd1, "prio_ex");
        step();
        apply_stimulus(0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output(0, 1'b0, 2'd1, 2'd1, 32'd1, "prio_ex_advance");
        step();
        apply_stimulus(0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(0, 1'b0, 2'd2, 2'd2, 32'd1, "prio_mem");
        step();
        idle(3);

        // A younger ALU write in EX masks an older load of the same register in MEM.
        apply_stimulus(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        apply_stimulus(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        apply_stimulus(0, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(0, 1'b0, 2'd1, 2'd0, 32'd1, "mask_older_load");
        step();
        idle(3);

        // Without forwarding: stall until WB retires, then saturate the 2-bit counter.
        do_reset();
        apply_stimulus(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        check_output(1, 1'b0, 2'd0, 2'd0, 32'd0, "nofwd_issue");
        step();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_output(1, 1'b1, 2'd0, 2'd0, i, $sformatf("nofwd_stall%0d", i));
            step();
        end
        apply_stimulus(1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_output(1, 1'b0, 2'd0, 2'd0, 32'd3, "nofwd_released");
        step();
        apply_stimulus(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1, 5'd0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_output(1, 1'b1, 2'd0, 2'd0, 32'd3, $sformatf("nofwd_saturate%0d", i));
            step();
        end
        apply_stimulus(1, 5'd0, 1'b0, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(1, 1'b0, 2'd0, 2'd0, 32'd3, "nofwd_saturated_hold");
        step();

        // Reset mid-flight with r9 producers in every slot.
        do_reset();
        apply_stimulus(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        step();
        apply_stimulus(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        apply_stimulus(0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(0, 1'b1, 2'd1, 2'd1, 32'd0, "r9_before_reset");
        step();
        check_output(0, 1'b1, 2'd1, 2'd1, 32'd1, "r9_counted");
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_output(0, 1'b0, 2'd0, 2'd0, 32'd0, "r9_after_reset");
        step();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Centralised RAW hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Tracks destination tags of instructions in EX, MEM and WB in internal slots, which advance on per-stage handshakes.
- Drives the ID-stage stall plus per-read-port forwarding selects; ID uses these to choose source operands from the RF or a downstream stage.
- Replaces the ad-hoc address comparison inside ID and adds load-use detection and a stall performance counter.

Parameters:
FWD_EN, 1, 1 = forwarding enabled; 0 = any RAW match stalls and selects stay 0
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rj  in  5  ID read address port 1
id_rj_re  in  1  port 1 actually read
id_rkd  in  5  ID read address port 2 (rk or rd)
id_rkd_re  in  1  port 2 actually read
id_dest  in  5  ID destination register
id_we  in  1  ID instruction writes GPR
id_is_load  in  1  ID instruction is ld.w
id_go  in  1  ID instruction moves to EX this cycle
ex_go  in  1  EX instruction moves to MEM
mem_go  in  1  MEM instruction moves to WB
wb_go  in  1  WB instruction retires (RF written)
stall  out  1  ID must hold; RAW hazard unresolved
fwd_sel1  out  2  port 1 source: 0 RF, 1 EX, 2 MEM, 3 WB
fwd_sel2  out  2  port 2 source, same encoding
stall_cnt  out  CNT_W  cycles with stall=1, saturating

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Slots: EX, MEM, WB. Each slot holds {v, we, dest[4:0], ld}.
- A slot is "producing" when v & we & dest!=0.
- EX slot:
  - On id_go: loads {1, id_we, id_dest, id_is_load}.
  - Else on ex_go: v is cleared.
- MEM slot:
  - On ex_go: loads the EX slot contents.
  - Else on mem_go: v is cleared.
- WB slot:
  - On mem_go: loads the MEM slot contents.
  - Else on wb_go: v is cleared.
- Simultaneous load and advance in the same cycle: the load wins, giving shift-register behaviour.
- Match on port p against slot s: s is producing, s.dest == addr_p, and re_p=1. Reads of r0 never match.
- Forward select, per port: the youngest matching slot wins, priority EX > MEM > WB. No match gives 0. Selects are combinational and valid whenever id_valid=1.
- Stall when FWD_EN=1: stall = id_valid & (a port's youngest match is the EX slot with ld=1). Load data is available only from MEM onward.
- Stall when FWD_EN=0: stall = id_valid & any match on any port. fwd_sel1 and fwd_sel2 are tied to 0.
- A younger non-load EX match masks an older MEM/WB load match. No stall results from it.
- The environment guarantees id_go=0 while stall=1. The bench asserts this.
- Reset outputs:
  - All slot v bits clear.
  - stall=0, fwd_sel1=fwd_sel2=0, stall_cnt=0.
- Reset mid-operation discards all slots in the same edge.
- stall_cnt increments on each clk edge where stall=1. It saturates at all-ones.
- Latency: stall and fwd_sel are zero-cycle (combinational) from the ID inputs and the slot registers. Slots update one edge after the handshake.
- Block size: about 150 lines of RTL.

Test Plan:
- Dependent ALU ops:
  - Stimulus: add.w r5 (id_go), next cycle add.w reading r5 on port 1, all *_go=1.
  - Required: stall=0, fwd_sel1=1. One cycle later in MEM: fwd_sel1=2.
- Load-use:
  - Stimulus: ld.w r7 issued, dependent add reading r7 on port 2.
  - Required: stall=1 for exactly 1 cycle, stall_cnt=1, then fwd_sel2=2 with stall=0.
- r0 and disabled reads:
  - Stimulus: producer with dest=0, or id_rkd_re=0 while addresses match.
  - Required: fwd_sel=0, stall=0.
- Priority:
  - Stimulus: r3 written by instructions in EX, MEM and WB simultaneously, ID reads r3 on both ports.
  - Required: fwd_sel1=fwd_sel2=1. Remove the EX producer and the selects become 2.
- FWD_EN=0:
  - Stimulus: add r4, then dependent read of r4 with pipeline flowing.
  - Required: stall=1 for 3 cycles until WB retires, sel stays 0, stall_cnt=3.
- Reset mid-flight:
  - Stimulus: slots full of r9 producers, reset=1 one cycle, ID reads r9.
  - Required: fwd_sel=0, stall=0, stall_cnt=0.
